// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// MEM stage of the 16-bit MISC-V pipeline. It sits directly downstream of the
// Execute stage and contains:
//   - the EX/MEM pipeline register,
//   - a req/ack data-memory access FSM with an optional timeout,
//   - the MEM/WB pipeline register, which feeds the writeback stage.
//
// The ALU result held in EX/MEM is exported as a forwarding source for EX.
// While a memory access is outstanding, a stall freezes IF/ID/EX.
//
// Parameters
//   TIMEOUT  maximum number of cycles a request waits for dmem_ack
//            (0 = wait forever)
//   CNT_W    width of the timeout counter (TIMEOUT < 2**CNT_W)
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   IRegWrite .. IRd            instruction fields arriving from EX
//   dmem_req/we/addr/wdata      request side of the data-memory port
//   dmem_rdata, dmem_ack        response side of the data-memory port
//   ALUResultMEM                EX/MEM ALU result, to the EX forwarding muxes
//   stall                       1 = upstream must hold; EX/MEM is not reloaded
//   bus_err                     sticky timeout flag, cleared only by reset
//   ORegWrite .. ORd            MEM/WB register outputs, to writeback
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  // From EX
  input  logic        IRegWrite,
  input  logic        IRegStore,
  input  logic        IMemWrite,
  input  logic        IMemRead,
  input  logic [15:0] IPCP2,
  input  logic [15:0] IALUResult,
  input  logic [15:0] I3rdArg,
  input  logic [15:0] IRd,
  // Data memory
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  // Forwarding / hazard / status
  output logic [15:0] ALUResultMEM,
  output logic        stall,
  output logic        bus_err,
  // MEM/WB
  output logic        ORegWrite,
  output logic        ORegStore,
  output logic [15:0] OPCP2,
  output logic [15:0] OALUResult,
  output logic [15:0] OLoadData,
  output logic [15:0] ORd
);

  localparam bit               TIMEOUT_EN  = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // EX/MEM pipeline register
  // ---------------------------------------------------------------------------
  logic        ex_regwrite_reg;
  logic        ex_regstore_reg;
  logic        ex_memwrite_reg;
  logic        ex_memread_reg;
  logic [15:0] ex_pcp2_reg;
  logic [15:0] ex_alu_reg;
  logic [15:0] ex_arg3_reg;
  logic [15:0] ex_rd_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_regwrite_reg <= 1'b0;
      ex_regstore_reg <= 1'b0;
      ex_memwrite_reg <= 1'b0;
      ex_memread_reg  <= 1'b0;
      ex_pcp2_reg     <= 16'h0000;
      ex_alu_reg      <= 16'h0000;
      ex_arg3_reg     <= 16'h0000;
      ex_rd_reg       <= 16'h0000;
    end else if (!stall) begin
      ex_regwrite_reg <= IRegWrite;
      ex_regstore_reg <= IRegStore;
      ex_memwrite_reg <= IMemWrite;
      ex_memread_reg  <= IMemRead;
      ex_pcp2_reg     <= IPCP2;
      ex_alu_reg      <= IALUResult;
      ex_arg3_reg     <= I3rdArg;
      ex_rd_reg       <= IRd;
    end
  end

  logic memop;
  logic ack_ok;
  logic timeout_hit;

  assign memop  = ex_memread_reg | ex_memwrite_reg;
  // An ack that arrives with no request outstanding is not ours; ignore it.
  assign ack_ok = dmem_ack & memop;

  // ---------------------------------------------------------------------------
  // Access FSM: state register
  // ---------------------------------------------------------------------------
  state_t           state_reg,  state_next;
  logic [CNT_W-1:0] count_reg,  count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // Timeout fires only on a cycle with no ack, so a late ack that lands on the
  // final wait cycle still completes the access cleanly.
  assign timeout_hit = TIMEOUT_EN && (state_reg == ST_WAIT) &&
                       (count_reg == TIMEOUT_CNT) && !dmem_ack;

  // ---------------------------------------------------------------------------
  // Access FSM: next-state logic
  // ---------------------------------------------------------------------------
  // DONE is the cycle after a completed access. By then EX/MEM has already
  // been reloaded with the next instruction, so DONE evaluates that new
  // instruction exactly as IDLE would; this is what lets back-to-back memory
  // ops issue without an extra dead cycle.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (memop && !dmem_ack) begin
          state_next = ST_WAIT;
          count_next = CNT_W'(1);
        end else begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      end
      ST_WAIT: begin
        if (dmem_ack || timeout_hit) begin
          state_next = ST_DONE;
          count_next = '0;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        count_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access FSM: outputs
  // ---------------------------------------------------------------------------
  // EX/MEM is frozen while waiting, so address, direction and write data are
  // automatically held stable for the whole request.
  always_comb begin
    dmem_req = 1'b0;
    case (state_reg)
      ST_WAIT: dmem_req = 1'b1;
      default: dmem_req = memop;
    endcase
    stall = memop & ~dmem_ack & ~timeout_hit;
  end

  // A simultaneous read+write is treated as a write.
  assign dmem_we      = ex_memwrite_reg;
  assign dmem_addr    = ex_alu_reg;
  assign dmem_wdata   = ex_arg3_reg;
  assign ALUResultMEM = ex_alu_reg;

  // ---------------------------------------------------------------------------
  // Sticky bus error
  // ---------------------------------------------------------------------------
  logic bus_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_err_reg <= 1'b0;
    end else if (timeout_hit) begin
      bus_err_reg <= 1'b1;
    end
  end

  assign bus_err = bus_err_reg;

  // ---------------------------------------------------------------------------
  // MEM/WB pipeline register
  // ---------------------------------------------------------------------------
  // While stalled a full bubble is inserted, so the held instruction reaches
  // writeback exactly once: on the edge where its access completes.
  logic        wb_regwrite_reg;
  logic        wb_regstore_reg;
  logic [15:0] wb_pcp2_reg;
  logic [15:0] wb_alu_reg;
  logic [15:0] wb_load_reg;
  logic [15:0] wb_rd_reg;

  always_ff @(posedge clk) begin
    if (reset || stall) begin
      wb_regwrite_reg <= 1'b0;
      wb_regstore_reg <= 1'b0;
      wb_pcp2_reg     <= 16'h0000;
      wb_alu_reg      <= 16'h0000;
      wb_load_reg     <= 16'h0000;
      wb_rd_reg       <= 16'h0000;
    end else begin
      // A timed-out access must not write back: its load data is invalid.
      wb_regwrite_reg <= ex_regwrite_reg & ~timeout_hit;
      wb_regstore_reg <= ex_regstore_reg;
      wb_pcp2_reg     <= ex_pcp2_reg;
      wb_alu_reg      <= ex_alu_reg;
      wb_load_reg     <= ack_ok ? dmem_rdata : 16'h0000;
      wb_rd_reg       <= ex_rd_reg;
    end
  end

  assign ORegWrite  = wb_regwrite_reg;
  assign ORegStore  = wb_regstore_reg;
  assign OPCP2      = wb_pcp2_reg;
  assign OALUResult = wb_alu_reg;
  assign OLoadData  = wb_load_reg;
  assign ORd        = wb_rd_reg;

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//
// Scoreboard bench for memory_stage. The driver issues directed instructions
// and pushes the hand-computed MEM/WB result into exp_q and the expected memory
// access into plan_q. A memory responder answers requests according to
// plan_q, and a monitor pops exp_q whenever a real instruction (OPCP2 != 0)
// reaches MEM/WB. Bubbles and NOPs carry OPCP2 = 0.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  localparam int TIMEOUT = 4;
  localparam int NEVER   = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRegWrite, IRegStore, IMemWrite, IMemRead;
  logic [15:0] IPCP2, IALUResult, I3rdArg, IRd;
  logic [15:0] dmem_rdata;
  logic        dmem_ack;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [15:0] ALUResultMEM;
  logic        stall, bus_err;
  logic        ORegWrite, ORegStore;
  logic [15:0] OPCP2, OALUResult, OLoadData, ORd;

  always #5 clk = ~clk;

  memory_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .IRegWrite(IRegWrite), .IRegStore(IRegStore), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IPCP2(IPCP2), .IALUResult(IALUResult), .I3rdArg(I3rdArg), .IRd(IRd),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .ALUResultMEM(ALUResultMEM), .stall(stall), .bus_err(bus_err),
    .ORegWrite(ORegWrite), .ORegStore(ORegStore), .OPCP2(OPCP2),
    .OALUResult(OALUResult), .OLoadData(OLoadData), .ORd(ORd)
  );

  typedef struct {
    logic        regwrite;
    logic        regstore;
    logic [15:0] pcp2;
    logic [15:0] alu;
    logic [15:0] load;
    logic [15:0] rd;
    int          gap;     // expected bubbles since previous retirement, -1 = don't care
  } wb_t;

  typedef struct {
    int          waits;   // ack on the (waits)-th cycle after the request appears
    logic [15:0] rdata;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          exp_stall;
  } acc_t;

  wb_t  exp_q[$];
  acc_t plan_q[$];
  int   checks   = 0;
  int   failures = 0;
  logic stray_ack = 1'b0;
  logic mon_en    = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic plan(input int waits, input logic [15:0] rdata, input logic we,
                      input logic [15:0] addr, input logic [15:0] wdata, input int exp_stall);
    plan_q.push_back('{waits: waits, rdata: rdata, we: we, addr: addr, wdata: wdata,
                       exp_stall: exp_stall});
  endtask

  // Present one instruction, hold it while stalled, and return one step after
  // the edge that captures it into EX/MEM. Inputs revert to a NOP afterwards.
  task automatic issue(input logic rw, input logic rs, input logic mw, input logic mr,
                       input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] a3,
                       input logic [15:0] rd, input logic push, input logic exp_rw,
                       input logic [15:0] exp_load, input int gap);
    int guard;
    @(negedge clk);
    IRegWrite = rw; IRegStore = rs; IMemWrite = mw; IMemRead = mr;
    IPCP2 = pc; IALUResult = alu; I3rdArg = a3; IRd = rd;
    if (push)
      exp_q.push_back('{regwrite: exp_rw, regstore: rs, pcp2: pc, alu: alu,
                        load: exp_load, rd: rd, gap: gap});
    #2;
    guard = 0;
    while (stall === 1'b1 && guard < 50) begin
      @(negedge clk);
      #2;
      guard++;
    end
    if (guard >= 50) check("issue_stall_bound", 1, 0);
    @(posedge clk);
    #1;
    check($sformatf("alu_fwd[pc=%h]", pc), ALUResultMEM, alu);
    IRegWrite = 0; IRegStore = 0; IMemWrite = 0; IMemRead = 0;
    IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0;
  endtask

  task automatic nop();
    issue(0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 0, 0, 16'h0, -1);
  endtask

  // Memory responder
  initial begin
    bit   active;
    bit   moved;
    int   cnt;
    acc_t cur;
    active = 0; moved = 0; cnt = 0;
    cur = '{waits: 0, rdata: 16'h0, we: 1'b0, addr: 16'h0, wdata: 16'h0, exp_stall: 0};
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (dmem_req === 1'b1) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            check("unplanned_request", 1, 0);
            cur = '{waits: 0, rdata: 16'h0, we: 1'b0, addr: 16'h0, wdata: 16'h0, exp_stall: 0};
          end else begin
            cur = plan_q.pop_front();
          end
          active = 1; cnt = 0; moved = 0;
        end
        if (dmem_addr !== cur.addr || dmem_we !== cur.we || dmem_wdata !== cur.wdata)
          moved = 1;
        dmem_ack   = (cnt == cur.waits);
        dmem_rdata = dmem_ack ? cur.rdata : 16'h0;
        #1;
        if (stall === 1'b0) begin
          check($sformatf("req_stable[addr=%h]", cur.addr), moved, 0);
          check($sformatf("stall_cycles[addr=%h]", cur.addr), cnt, cur.exp_stall);
          active = 0;
        end else begin
          cnt++;
        end
      end else begin
        active     = 0;
        dmem_ack   = stray_ack;
        dmem_rdata = stray_ack ? 16'hDEAD : 16'h0;
        stray_ack  = 1'b0;
      end
    end
  end

  // MEM/WB monitor
  initial begin
    int  gap;
    wb_t e;
    gap = 0;
    wait (mon_en === 1'b1);
    forever begin
      @(negedge clk);
      #3;
      if (OPCP2 !== 16'h0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_retire", OPCP2, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("wb_regwrite[pc=%h]", e.pcp2), ORegWrite, e.regwrite);
          check($sformatf("wb_regstore[pc=%h]", e.pcp2), ORegStore, e.regstore);
          check($sformatf("wb_pcp2[pc=%h]", e.pcp2), OPCP2, e.pcp2);
          check($sformatf("wb_alu[pc=%h]", e.pcp2), OALUResult, e.alu);
          check($sformatf("wb_load[pc=%h]", e.pcp2), OLoadData, e.load);
          check($sformatf("wb_rd[pc=%h]", e.pcp2), ORd, e.rd);
          if (e.gap >= 0) check($sformatf("wb_gap[pc=%h]", e.pcp2), gap, e.gap);
        end
        gap = 0;
      end else begin
        gap++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Directed stimulus
  initial begin
    reset = 1'b1;
    IRegWrite = 0; IRegStore = 0; IMemWrite = 0; IMemRead = 0;
    IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_oregwrite", ORegWrite, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_stall", stall, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_opcp2", OPCP2, 0);
    check("rst_alu_fwd", ALUResultMEM, 0);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // 1. Plain ALU op, then a second one with a stray ack (must be ignored).
    issue(1, 0, 0, 0, 16'h0102, 16'h1234, 16'h0, 16'd3, 1, 1, 16'h0, -1);
    check("alu_no_stall", stall, 0);
    issue(1, 0, 0, 0, 16'h0104, 16'h5678, 16'h0, 16'd4, 1, 1, 16'h0, 0);
    stray_ack = 1'b1;

    // 2. Zero-wait load.
    plan(0, 16'hBEEF, 0, 16'h0040, 16'h0, 0);
    issue(1, 1, 0, 1, 16'h0106, 16'h0040, 16'h0, 16'd5, 1, 1, 16'hBEEF, 0);

    // 3. Store acked after 3 wait cycles: three bubbles precede it in MEM/WB.
    plan(3, 16'h0, 1, 16'h0010, 16'hA5A5, 3);
    issue(0, 0, 1, 0, 16'h0108, 16'h0010, 16'hA5A5, 16'd0, 1, 0, 16'h0, 3);

    // Ack on the same cycle the timeout compare matches: ack wins.
    plan(TIMEOUT, 16'h1111, 0, 16'h0020, 16'h0, TIMEOUT);
    issue(1, 1, 0, 1, 16'h010A, 16'h0020, 16'h0, 16'd6, 1, 1, 16'h1111, -1);

    // 4. Load that is never acked: times out, no writeback, sticky error.
    plan(NEVER, 16'h0, 0, 16'h0030, 16'h0, TIMEOUT);
    issue(1, 1, 0, 1, 16'h010C, 16'h0030, 16'h0, 16'd7, 1, 0, 16'h0, TIMEOUT);
    check("bus_err_before_timeout", bus_err, 0);
    issue(1, 0, 0, 0, 16'h010E, 16'h9999, 16'h0, 16'd8, 1, 1, 16'h0, 0);
    check("bus_err_set", bus_err, 1);
    nop();
    check("bus_err_sticky", bus_err, 1);

    // 5. Reset while in WAIT: the access is dropped.
    plan(NEVER, 16'h0, 0, 16'h0050, 16'h0, 0);
    issue(1, 1, 0, 1, 16'h0110, 16'h0050, 16'h0, 16'd9, 0, 0, 16'h0, -1);
    repeat (2) @(negedge clk);
    check("pre_reset_req", dmem_req, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_dmem_req", dmem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_bus_err", bus_err, 0);
    check("mid_rst_alu_fwd", ALUResultMEM, 0);
    check("mid_rst_wb", {ORegWrite, ORegStore, OPCP2, OALUResult, OLoadData, ORd}, 0);
    @(negedge clk);
    reset = 1'b0;
    plan(2, 16'hC0DE, 0, 16'h0060, 16'h0, 2);
    issue(1, 1, 0, 1, 16'h0112, 16'h0060, 16'h0, 16'd10, 1, 1, 16'hC0DE, -1);

    // 6. Back-to-back loads, one wait cycle each: one bubble between results.
    plan(1, 16'h0A01, 0, 16'h0070, 16'h0, 1);
    plan(1, 16'h0A02, 0, 16'h0071, 16'h0, 1);
    plan(1, 16'h0A03, 0, 16'h0072, 16'h0, 1);
    issue(1, 1, 0, 1, 16'h0114, 16'h0070, 16'h0, 16'd11, 1, 1, 16'h0A01, -1);
    issue(1, 1, 0, 1, 16'h0116, 16'h0071, 16'h0, 16'd12, 1, 1, 16'h0A02, 1);
    issue(1, 1, 0, 1, 16'h0118, 16'h0072, 16'h0, 16'd13, 1, 1, 16'h0A03, 1);

    repeat (3) nop();
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("plans_consumed", plan_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
